// File: rtl/mips_datapath_alu_muldiv_sequencer_pkg.sv
// mips_datapath_alu_muldiv_sequencer_pkg: op encodings, FSM states and word width shared by the mul/div sequencer.
package mips_datapath_alu_muldiv_sequencer_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP} state_e;
endpackage

// File: rtl/mips_datapath_alu_muldiv_sequencer_step.sv
// mips_datapath_alu_muldiv_step: one shift-add (multiply) or restoring-subtract (divide) iteration on a shared 33-bit adder.
module mips_datapath_alu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mq,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] mq_n
);
  logic [WIDTH:0] x, r, s;
  logic q;
  // remainder stays below the divisor, so bit WIDTH of the difference is the borrow
  always_comb begin
    x = div ? {acc, mq[WIDTH-1]} : {1'b0, acc};
    r = div ? x - {1'b0, opnd} : x + {1'b0, opnd};
    q = ~r[WIDTH];
    s = mq[0] ? r : x;
    acc_n = div ? (q ? r[WIDTH-1:0] : x[WIDTH-1:0]) : s[WIDTH:1];
    mq_n = div ? {mq[WIDTH-2:0], q} : {s[0], mq[WIDTH-1:1]};
  end
endmodule

// File: rtl/mips_datapath_alu_muldiv_sequencer.sv
// mips_datapath_alu_muldiv_sequencer: iterative MULT(U)/DIV(U) sequencer owning HI/LO; MIPS_DATAPATH_ALU_MULDIV_SIGNED_EN enables signed ops.
module mips_datapath_alu_muldiv_sequencer
  import mips_datapath_alu_muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             cancel,
  input  logic             readHiLo,
  output logic             ready,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_e state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd, acc, mq, acc_n, mq_n, a_mag, b_mag, quo_f, rem_f;
  logic [2*WIDTH-1:0] prod_f;
  logic is_div, neg_p, neg_r, dz, sgn, accept, md, write;

  assign ready = state == S_IDLE;
  assign busy = state == S_RUN || state == S_FIXUP;
  assign stall = readHiLo & busy;
  assign accept = ready & start & ~cancel;
  assign md = ~op[2];
  assign write = state == S_FIXUP && !cancel;
`ifdef MIPS_DATAPATH_ALU_MULDIV_SIGNED_EN
  assign sgn = ~op[0];
`else
  assign sgn = 1'b0;
`endif
  assign a_mag = (sgn & srcA[WIDTH-1]) ? -srcA : srcA;
  assign b_mag = (sgn & srcB[WIDTH-1]) ? -srcB : srcB;
  assign prod_f = neg_p ? -{acc, mq} : {acc, mq};
  assign quo_f = dz ? '1 : neg_p ? -mq : mq;
  assign rem_f = neg_r ? -acc : acc;

  mips_datapath_alu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div  (is_div),
    .acc  (acc),
    .mq   (mq),
    .opnd (opnd),
    .acc_n(acc_n),
    .mq_n (mq_n)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = (busy && cancel) ? S_IDLE :
              (state == S_IDLE) ? ((accept && md) ? S_RUN : S_IDLE) :
              (state == S_RUN) ? ((cnt == CNT_W'(WIDTH-1)) ? S_FIXUP : S_RUN) : S_IDLE;
  end

  // multiply keeps the multiplicand in opnd and shifts the multiplier out of mq;
  // divide keeps the divisor in opnd and shifts the dividend out of mq as quotient bits enter
  always_ff @(posedge clock) begin
    if (reset) begin
      {hi, lo, acc, mq, opnd} <= '0;
      cnt <= '0;
      {is_div, neg_p, neg_r, dz} <= '0;
    end else begin
      if (accept && md) begin
        cnt <= '0;
        is_div <= op[1];
        acc <= '0;
        opnd <= op[1] ? b_mag : a_mag;
        mq <= op[1] ? a_mag : b_mag;
        neg_p <= sgn & (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
        neg_r <= sgn & srcA[WIDTH-1];
        dz <= op[1] & ~|srcB;
      end else if (state == S_RUN) begin
        cnt <= cnt + CNT_W'(1);
        acc <= acc_n;
        mq <= mq_n;
      end
      if (accept && op == OP_MTHI) hi <= srcA;
      if (accept && op == OP_MTLO) lo <= srcA;
      if (write) begin
        hi <= is_div ? rem_f : prod_f[2*WIDTH-1:WIDTH];
        lo <= is_div ? quo_f : prod_f[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mips_datapath_alu_muldiv_sequencer.sv
// tb_mips_datapath_alu_muldiv_sequencer: scoreboard bench with an arithmetic reference model for the mul/div sequencer.
module tb_mips_datapath_alu_muldiv_sequencer;
  logic clock = 0, reset = 1, start = 0, cancel = 0, readHiLo = 0;
  logic [2:0] op = 0;
  logic [31:0] srcA = 0, srcB = 0;
  logic ready, busy, stall;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic pb = 0;

  always #5 clock = ~clock;

  mips_datapath_alu_muldiv_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .cancel(cancel), .readHiLo(readHiLo), .ready(ready), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic sg;
    longint sa, sb, q, r;
`ifdef MIPS_DATAPATH_ALU_MULDIV_SIGNED_EN
    sg = ~o[0];
`else
    sg = 1'b0;
`endif
    sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
    if (!o[1]) return sa * sb;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(negedge clock) begin
    if (pb && !busy && !reset) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_hilo actual=%h expected=<none queued>", {hi, lo});
      end else begin
        got = exp_q.pop_front();
        if ({hi, lo} !== got) begin
          bad++;
          $display("FAIL sb_hilo actual=%h expected=%h", {hi, lo}, got);
        end
      end
    end
    pb = busy;
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int cancel_at, input bit rd, input bit poke);
    logic [63:0] e;
    int n;
    @(negedge clock);
    start = 1; op = o; srcA = a; srcB = b; readHiLo = rd;
    #1;
    if (rd) check("stall_idle", stall, 0);
    @(posedge clock);
    if (!o[2]) begin
      e = (cancel_at >= 0) ? {m_hi, m_lo} : ref_md(o, a, b);
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
    end else if (o == 3'd4) m_hi = a;
    else if (o == 3'd5) m_lo = a;
    @(negedge clock);
    start = 0;
    if (o[2]) begin
      check("mt_hilo", {hi, lo}, {m_hi, m_lo});
      check("mt_ready", ready, 1);
    end else begin
      n = 0;
      while (busy && n < 100) begin
        if (rd) check("stall_busy", stall, 1);
        cancel = (n == cancel_at);
        start = poke && n == 5;
        if (start) begin op = 3'd4; srcA = 32'hDEAD_BEEF; end
        @(negedge clock);
        n++;
      end
      cancel = 0; start = 0;
      check("busy_cycles", n, cancel_at >= 0 ? cancel_at + 1 : 33);
    end
    readHiLo = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    int c;
    repeat (2) @(posedge clock);
    @(negedge clock);
    readHiLo = 1;
    #1;
    check("rst_hilo", {hi, lo}, 0);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    reset = 0; readHiLo = 0;
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0, 0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 0, 0);
    run_op(3'd3, 32'd100, 32'd0, -1, 0, 0);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, -1, 0, 0);
    run_op(3'd4, 32'h1234, 32'd0, -1, 1, 0);
    run_op(3'd1, 32'd2, 32'd3, -1, 1, 0);
    run_op(3'd1, 32'd5, 32'd6, 10, 0, 1);
    run_op(3'd0, 32'd5, 32'd6, 32, 0, 0);
    run_op(3'd6, 32'd1, 32'd2, -1, 0, 0);
    run_op(3'd7, 32'd1, 32'd2, -1, 1, 0);
    @(negedge clock);
    start = 1; op = 3'd5; srcA = 32'hABCD; cancel = 1;
    @(negedge clock);
    start = 0; cancel = 0;
    check("cancel_start_idle", {hi, lo}, {m_hi, m_lo});
    @(negedge clock);
    start = 1; op = 3'd2; srcA = 32'd100; srcB = 32'd7;
    @(negedge clock);
    start = 0;
    repeat (9) @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("midop_rst_hilo", {hi, lo}, 0);
    check("midop_rst_ready", ready, 1);
    m_hi = 0; m_lo = 0;
    @(negedge clock);
    reset = 0;
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 0);
    repeat (40) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      c = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32)) : -1;
      run_op(o, a, b, c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clock);
    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
